// File: rtl/pong_cmd_pkg.sv
// Shared constants, command/echo enums and the byte decoder for pong_uart_cmd.
package pong_cmd_pkg;

  localparam logic [7:0] KEY_UP_L   = 8'h57; // 'W'
  localparam logic [7:0] KEY_DN_L   = 8'h53; // 'S'
  localparam logic [7:0] KEY_UP_R   = 8'h49; // 'I'
  localparam logic [7:0] KEY_DN_R   = 8'h4B; // 'K'
  localparam logic [7:0] KEY_START0 = 8'h20; // ' '
  localparam logic [7:0] KEY_START1 = 8'h47; // 'G'
  localparam logic [7:0] CASE_MASK  = 8'hDF; // clears the ASCII lower-case bit

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP_L,
    CMD_DN_L,
    CMD_UP_R,
    CMD_DN_R,
    CMD_START,
    CMD_BAD
  } cmd_t;

  typedef enum logic {
    ECHO_EMPTY,
    ECHO_FULL
  } echo_st_t;

  // Space is compared raw because masking would fold it onto 8'h00.
  function automatic cmd_t decode_byte(input logic [7:0] b);
    logic [7:0] u;
    u = b & CASE_MASK;
    if (b == KEY_START0)      return CMD_START;
    else if (u == KEY_START1) return CMD_START;
    else if (u == KEY_UP_L)   return CMD_UP_L;
    else if (u == KEY_DN_L)   return CMD_DN_L;
    else if (u == KEY_UP_R)   return CMD_UP_R;
    else if (u == KEY_DN_R)   return CMD_DN_R;
    else                      return CMD_BAD;
  endfunction

endpackage

// File: rtl/pong_key_hold.sv
// Stretches one key event into HOLD_CYCLES cycles of a registered level.
module pong_key_hold
  import pong_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic active
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Reload has priority over clear and over the countdown reaching 1 or 0.
  always_comb begin
    cnt_next = cnt;
    if (load)
      cnt_next = CNT_W'(HOLD_CYCLES);
    else if (clear)
      cnt_next = '0;
    else if (cnt != '0)
      cnt_next = cnt - CNT_W'(1);
  end

  // Counter and its registered nonzero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/pong_uart_cmd.sv
// UART byte stream -> pong paddle levels, start strobe and bad-byte count.
// Optional echo path enabled by defining PONG_CMD_ECHO_EN.
module pong_uart_cmd
  import pong_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2_500_000,
  parameter int unsigned BAD_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             paddle_up_l,
  output logic             paddle_down_l,
  output logic             paddle_up_r,
  output logic             paddle_down_r,
  output logic             enable,
  output logic [BAD_W-1:0] bad_cnt
`ifdef PONG_CMD_ECHO_EN
  ,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
`endif
);

  cmd_t cmd;

  // Decode only when the receiver strobes a byte.
  always_comb begin
    cmd = CMD_NONE;
    if (rx_valid)
      cmd = decode_byte(rx_data);
  end

  // Opposite key of the same paddle clears the other direction.
  pong_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_up_l (
    .clk(clk), .reset(reset), .load(cmd == CMD_UP_L), .clear(cmd == CMD_DN_L),
    .active(paddle_up_l));
  pong_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_dn_l (
    .clk(clk), .reset(reset), .load(cmd == CMD_DN_L), .clear(cmd == CMD_UP_L),
    .active(paddle_down_l));
  pong_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_up_r (
    .clk(clk), .reset(reset), .load(cmd == CMD_UP_R), .clear(cmd == CMD_DN_R),
    .active(paddle_up_r));
  pong_key_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_dn_r (
    .clk(clk), .reset(reset), .load(cmd == CMD_DN_R), .clear(cmd == CMD_UP_R),
    .active(paddle_down_r));

  // Start strobe and saturating bad-byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable  <= 1'b0;
      bad_cnt <= '0;
    end else begin
      enable <= (cmd == CMD_START);
      if (cmd == CMD_BAD && bad_cnt != '1)
        bad_cnt <= bad_cnt + BAD_W'(1);
    end
  end

`ifdef PONG_CMD_ECHO_EN
  echo_st_t echo_st;
  echo_st_t echo_next;
  logic     echo_load;
  logic     accepted;

  assign accepted = (cmd != CMD_NONE) && (cmd != CMD_BAD);
  assign tx_valid = (echo_st == ECHO_FULL);

  // One-entry buffer: keeps the oldest byte until drained; refills on a drain cycle.
  always_comb begin
    echo_next = echo_st;
    echo_load = 1'b0;
    case (echo_st)
      ECHO_EMPTY: begin
        if (accepted) begin
          echo_next = ECHO_FULL;
          echo_load = 1'b1;
        end
      end
      ECHO_FULL: begin
        if (tx_ready) begin
          if (accepted)
            echo_load = 1'b1;
          else
            echo_next = ECHO_EMPTY;
        end
      end
      default: echo_next = ECHO_EMPTY;
    endcase
  end

  // Echo state and data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_st <= ECHO_EMPTY;
      tx_data <= 8'h00;
    end else begin
      echo_st <= echo_next;
      if (echo_load)
        tx_data <= rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_pong_uart_cmd.sv
// Directed self-checking bench for pong_uart_cmd (HOLD_CYCLES=8, BAD_W=8).
// Echo scenario runs only when PONG_CMD_ECHO_EN is defined.
module tb_pong_uart_cmd;

  localparam int unsigned HOLD  = 8;
  localparam int unsigned BAD_W = 8;

  logic             clk;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             paddle_up_l;
  logic             paddle_down_l;
  logic             paddle_up_r;
  logic             paddle_down_r;
  logic             enable;
  logic [BAD_W-1:0] bad_cnt;
`ifdef PONG_CMD_ECHO_EN
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
`endif

  int checks;
  int errors;

  pong_uart_cmd #(.HOLD_CYCLES(HOLD), .BAD_W(BAD_W)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .paddle_up_l(paddle_up_l),
    .paddle_down_l(paddle_down_l),
    .paddle_up_r(paddle_up_r),
    .paddle_down_r(paddle_down_r),
    .enable(enable),
    .bad_cnt(bad_cnt)
`ifdef PONG_CMD_ECHO_EN
    ,
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; byte is sampled at the next posedge, returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'hA5;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({paddle_up_l, paddle_down_l, paddle_up_r, paddle_down_r, enable} !== 5'b0) begin
      errors++;
      $display("FAIL reset_levels got %b want 00000",
               {paddle_up_l, paddle_down_l, paddle_up_r, paddle_down_r, enable});
    end
    checks++;
    if (bad_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_bad_cnt got %0d want 0", bad_cnt);
    end
`ifdef PONG_CMD_ECHO_EN
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx got valid=%b data=%h want 0/00", tx_valid, tx_data);
    end
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold();
    send_byte(8'h77); // 'w'
    for (int i = 0; i < int'(HOLD); i++) begin
      checks++;
      if (paddle_up_l !== 1'b1 ||
          {paddle_down_l, paddle_up_r, paddle_down_r, enable} !== 4'b0) begin
        errors++;
        $display("FAIL hold_up_l cycle %0d got up_l=%b others=%b want 1/0000", i, paddle_up_l,
                 {paddle_down_l, paddle_up_r, paddle_down_r, enable});
      end
      @(negedge clk);
    end
    checks++;
    if (paddle_up_l !== 1'b0) begin
      errors++;
      $display("FAIL hold_end got %b want 0", paddle_up_l);
    end
  endtask

  task automatic test_opposite();
    send_byte(8'h69); // 'i'
    checks++;
    if (paddle_up_r !== 1'b1 || paddle_down_r !== 1'b0) begin
      errors++;
      $display("FAIL opp_first got up_r=%b dn_r=%b want 1/0", paddle_up_r, paddle_down_r);
    end
    repeat (2) @(negedge clk);
    send_byte(8'h4B); // 'K'
    checks++;
    if (paddle_up_r !== 1'b0 || paddle_down_r !== 1'b1) begin
      errors++;
      $display("FAIL opp_swap got up_r=%b dn_r=%b want 0/1", paddle_up_r, paddle_down_r);
    end
    for (int i = 0; i < int'(HOLD) + 2; i++) begin
      @(negedge clk);
      checks++;
      if (paddle_up_r === 1'b1 && paddle_down_r === 1'b1) begin
        errors++;
        $display("FAIL opp_both cycle %0d got 11 want not both", i);
      end
    end
    checks++;
    if (paddle_down_r !== 1'b0 || paddle_up_l !== 1'b0) begin
      errors++;
      $display("FAIL opp_drain got dn_r=%b up_l=%b want 0/0", paddle_down_r, paddle_up_l);
    end
  endtask

  task automatic test_repeat();
    for (int k = 0; k < 6; k++) begin
      send_byte(8'h53); // 'S'
      checks++;
      if (paddle_down_l !== 1'b1) begin
        errors++;
        $display("FAIL repeat_load press %0d got %b want 1", k, paddle_down_l);
      end
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        checks++;
        if (paddle_down_l !== 1'b1) begin
          errors++;
          $display("FAIL repeat_gap press %0d step %0d got %b want 1", k, j, paddle_down_l);
        end
      end
    end
    repeat (HOLD) @(negedge clk);
    checks++;
    if (paddle_down_l !== 1'b0) begin
      errors++;
      $display("FAIL repeat_end got %b want 0", paddle_down_l);
    end
  endtask

  task automatic test_enable_bad();
    send_byte(8'h20); // ' '
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL enable_space got %b want 1", enable);
    end
    send_byte(8'h47); // 'G' back to back
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL enable_g got %b want 1", enable);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0 || bad_cnt !== 8'd0) begin
      errors++;
      $display("FAIL enable_end got en=%b bad=%0d want 0/0", enable, bad_cnt);
    end
    for (int n = 1; n <= 300; n++) begin
      send_byte(8'h78); // 'x'
      if (n == 1 || n == 254 || n == 255 || n == 300) begin
        checks++;
        if (bad_cnt !== ((n > 255) ? 8'd255 : 8'(n))) begin
          errors++;
          $display("FAIL bad_cnt after %0d got %0d want %0d", n, bad_cnt,
                   (n > 255) ? 255 : n);
        end
      end
    end
    checks++;
    if ({paddle_up_l, paddle_down_l, paddle_up_r, paddle_down_r, enable} !== 5'b0) begin
      errors++;
      $display("FAIL bad_no_action got %b want 00000",
               {paddle_up_l, paddle_down_l, paddle_up_r, paddle_down_r, enable});
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'h77); // 'w'
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (paddle_up_l !== 1'b0 || bad_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got up_l=%b bad=%0d want 0/0", paddle_up_l, bad_cnt);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(HOLD) + 2; i++) begin
      checks++;
      if (paddle_up_l !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d got %b want 0", i, paddle_up_l);
      end
      @(negedge clk);
    end
  endtask

`ifdef PONG_CMD_ECHO_EN
  task automatic test_echo();
    tx_ready = 1'b0;
    send_byte(8'h77); // 'w'
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL echo_first got valid=%b data=%h want 1/77", tx_valid, tx_data);
    end
    send_byte(8'h73); // 's' dropped from echo, still decoded
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77 || paddle_down_l !== 1'b1 ||
        paddle_up_l !== 1'b0) begin
      errors++;
      $display("FAIL echo_drop got valid=%b data=%h dn_l=%b up_l=%b want 1/77/1/0",
               tx_valid, tx_data, paddle_down_l, paddle_up_l);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL echo_drain got %b want 0", tx_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL echo_idle got %b want 0", tx_valid);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
`ifdef PONG_CMD_ECHO_EN
    tx_ready = 1'b0;
`endif
    test_reset();
    test_hold();
    test_opposite();
    test_repeat();
    test_enable_bad();
    test_async_reset();
`ifdef PONG_CMD_ECHO_EN
    test_echo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
